// File: rtl/byte_bus_master.sv
// byte_bus_master
//   Turns a byte stream into single-beat bus transactions.
//   Command frames:
//     'W' (0x57), AddrBytes address bytes, DataBytes data bytes -> one write, ack 0x4B
//     'R' (0x52), AddrBytes address bytes                       -> one read, DataBytes
//                                                                  response bytes, MSB first
//   Ports:
//     clk_i, reset_i            clock, synchronous active-high reset
//     rx_data_i / rx_valid_i    incoming byte stream (no backpressure)
//     tx_data_o / tx_valid_o    response byte stream
//     tx_busy_i                 downstream almost-full; stalls the response
//     bus_addr_o / bus_wdata_o  transaction address and write data
//     bus_we_o / bus_re_o       single-cycle write / read strobes
//     bus_rdata_i               read data, valid ReadLatency cycles after bus_re_o
//     error_o                   single-cycle pulse on any protocol error
module byte_bus_master #(
  parameter int AddrBytes     = 4,
  parameter int DataBytes     = 4,
  parameter int ReadLatency   = 2,
  parameter int TimeoutCycles = 1023
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [7:0]             rx_data_i,
  input  logic                   rx_valid_i,
  output logic [7:0]             tx_data_o,
  output logic                   tx_valid_o,
  input  logic                   tx_busy_i,
  output logic [8*AddrBytes-1:0] bus_addr_o,
  output logic [8*DataBytes-1:0] bus_wdata_o,
  output logic                   bus_we_o,
  output logic                   bus_re_o,
  input  logic [8*DataBytes-1:0] bus_rdata_i,
  output logic                   error_o
);

  localparam int AW   = 8 * AddrBytes;
  localparam int DW   = 8 * DataBytes;
  localparam int MAXB = (AddrBytes > DataBytes) ? AddrBytes : DataBytes;
  localparam int BW   = $clog2(MAXB + 1);
  localparam int TW   = $clog2(TimeoutCycles + 1);
  localparam int LW   = $clog2(ReadLatency + 1);
  localparam int RW   = $clog2(DataBytes + 1);

  localparam logic [BW-1:0] A_LAST = BW'(AddrBytes - 1);
  localparam logic [BW-1:0] D_LAST = BW'(DataBytes - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TimeoutCycles - 1);
  localparam logic [LW-1:0] L_LAST = LW'(ReadLatency);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, WRITE, RWAIT, RESP} state_t;

  state_t          state;
  logic            rd_mode;
  logic [BW-1:0]   bcnt;
  logic [TW-1:0]   icnt;
  logic [LW-1:0]   lcnt;
  logic [RW-1:0]   rcnt;
  logic [AW-1:0]   addr_sh;
  logic [DW-1:0]   wdata_sh;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   resp_q;
  logic            we_q;
  logic            re_q;
  logic            err_q;

  logic [AW-1:0]   addr_nx;
  logic [DW-1:0]   wdata_nx;

  // Frame bytes collect in shadow registers; the bus outputs only change when
  // a frame completes, so an aborted frame never disturbs them.
  assign addr_nx  = (addr_sh << 8) | AW'(rx_data_i);
  assign wdata_nx = (wdata_sh << 8) | DW'(rx_data_i);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state    <= IDLE;
      rd_mode  <= 1'b0;
      bcnt     <= '0;
      icnt     <= '0;
      lcnt     <= '0;
      rcnt     <= '0;
      addr_sh  <= '0;
      wdata_sh <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      resp_q   <= '0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      we_q  <= 1'b0;
      re_q  <= 1'b0;
      err_q <= 1'b0;
      // Bytes arriving while a transaction is in flight are dropped.
      if (rx_valid_i && (state == WRITE || state == RWAIT || state == RESP))
        err_q <= 1'b1;

      case (state)
        IDLE: begin
          if (rx_valid_i) begin
            bcnt <= '0;
            icnt <= '0;
            if (rx_data_i == 8'h57) begin
              rd_mode <= 1'b0;
              state   <= ADDR;
            end else if (rx_data_i == 8'h52) begin
              rd_mode <= 1'b1;
              state   <= ADDR;
            end else begin
              err_q <= 1'b1;
            end
          end
        end

        ADDR: begin
          if (rx_valid_i) begin
            icnt    <= '0;
            addr_sh <= addr_nx;
            if (bcnt == A_LAST) begin
              bcnt <= '0;
              if (rd_mode) begin
                addr_q <= addr_nx;
                re_q   <= 1'b1;
                lcnt   <= '0;
                state  <= RWAIT;
              end else begin
                state <= DATA;
              end
            end else begin
              bcnt <= bcnt + BW'(1);
            end
          end else if (icnt == T_LAST) begin
            icnt  <= '0;
            bcnt  <= '0;
            err_q <= 1'b1;
            state <= IDLE;
          end else begin
            icnt <= icnt + TW'(1);
          end
        end

        DATA: begin
          if (rx_valid_i) begin
            icnt     <= '0;
            wdata_sh <= wdata_nx;
            if (bcnt == D_LAST) begin
              bcnt    <= '0;
              addr_q  <= addr_sh;
              wdata_q <= wdata_nx;
              we_q    <= 1'b1;
              state   <= WRITE;
            end else begin
              bcnt <= bcnt + BW'(1);
            end
          end else if (icnt == T_LAST) begin
            icnt  <= '0;
            bcnt  <= '0;
            err_q <= 1'b1;
            state <= IDLE;
          end else begin
            icnt <= icnt + TW'(1);
          end
        end

        WRITE: begin
          resp_q <= DW'(8'h4B) << (DW - 8);
          rcnt   <= RW'(1);
          state  <= RESP;
        end

        // lcnt is 0 in the cycle bus_re_o is high, so the capture lands
        // exactly ReadLatency cycles after the strobe.
        RWAIT: begin
          if (lcnt == L_LAST) begin
            resp_q <= bus_rdata_i;
            rcnt   <= RW'(DataBytes);
            state  <= RESP;
          end else begin
            lcnt <= lcnt + LW'(1);
          end
        end

        RESP: begin
          if (!tx_busy_i) begin
            resp_q <= resp_q << 8;
            rcnt   <= rcnt - RW'(1);
            if (rcnt == RW'(1))
              state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // tx_valid_o follows tx_busy_i in the same cycle so nothing is issued
  // while downstream is almost full.
  assign tx_valid_o  = (state == RESP) && !tx_busy_i;
  assign tx_data_o   = resp_q[DW-1 -: 8];
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign bus_we_o    = we_q;
  assign bus_re_o    = re_q;
  assign error_o     = err_q;

endmodule
